datapath_controller: RTL and testbench
======================================

// Module: datapath_controller
// PURPOSE
//  Control unit (FSM) driving the 4-bit A/B datapath: issues ALoad, BLoad, Muxsel, out_ctrl
//  in sequence and consumes Astatus (A==4'b0101). One run: load A from DinA, test A, load
//  B with 8 (match) or 13 (no match), publish B on DoutB. start/busy/done handshake to the host.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles in CHECK before Astatus is sampled; legal range 1..15
//  OUT_CYCLES     1  cycles out_ctrl is held high in OUTPUT; legal range 1..15
// PORTS
//  clock     in   1  single clock, rising edge
//  reset     in   1  asynchronous, active-high; forces IDLE immediately
//  start     in   1  run request, sampled only in IDLE
//  Astatus   in   1  datapath flag, 1 when A==4'b0101
//  ALoad     out  1  datapath A-load strobe
//  BLoad     out  1  datapath B-load strobe
//  Muxsel    out  1  B source select: 1 -> 8, 0 -> 13
//  out_ctrl  out  1  datapath DoutB<=B strobe
//  busy      out  1  high in every state except IDLE
//  done      out  1  one-cycle pulse, run complete
//  match     out  1  registered Astatus sample from the last run
// BEHAVIOUR
//  Reset: state=IDLE; ALoad=BLoad=Muxsel=out_ctrl=busy=done=match=0; wait counter=0.
//   Takes effect asynchronously, including mid-run. Datapath A/B/DoutB are not reset.
//  Outputs are Moore: decoded from the registered state (plus sel_q/counter), no input paths.
//  States and transitions (one per clock edge):
//   IDLE   : all strobes 0. start=1 -> LOAD_A, else stay.
//   LOAD_A : ALoad=1 for exactly 1 cycle -> CHECK; counter loaded with SETTLE_CYCLES-1.
//   CHECK  : strobes 0. Counter!=0 -> decrement, stay. Counter==0 -> sel_q<=Astatus,
//            match<=Astatus, -> LOAD_B.
//   LOAD_B : BLoad=1 for exactly 1 cycle, Muxsel=sel_q -> OUTPUT; counter<=OUT_CYCLES-1.
//   OUTPUT : out_ctrl=1. Counter!=0 -> decrement, stay. Counter==0 -> DONE.
//   DONE   : done=1 for 1 cycle -> IDLE unconditionally.
//  Muxsel holds sel_q in all states (reset value 0); datapath ignores it outside LOAD_B.
//  Invariant: at most one of ALoad/BLoad/out_ctrl is 1 in any cycle (datapath decodes one-hot).
//  Latency (start seen at edge 0): LOAD_A cycle 1, CHECK 2..1+S, LOAD_B 2+S,
//   OUTPUT 3+S..2+S+O, DONE 3+S+O. Defaults: done in cycle 5; DoutB already valid then.
//  start while busy: ignored, no queuing. start held high: IDLE entered after DONE, new run
//   begins the following cycle (minimum 1 IDLE cycle between runs).
//  Astatus sampled exactly once per run (CHECK exit); changes at other times have no effect.
//  Counter: 4 bits, no wrap (only loaded in LOAD_A/LOAD_B, decremented while nonzero).
//  Reset mid-run: strobes drop at once; the partially loaded datapath is not restored;
//   next run after reset release fully reloads A, B, DoutB.
// STRUCTURE
//  Shared package datapath_ctrl_pkg: state encoding (3-bit, IDLE=0 .. DONE=5), constants
//   A_MATCH_VAL=4'b0101, B_MATCH_VAL=4'd8, B_NOMATCH_VAL=4'd13 (bench and datapath share them).
//  Sub-module ctrl_wait_counter: 4-bit loadable down-counter with zero flag, used for both
//   CHECK and OUTPUT waits. FSM next-state and output decode remain in this module.
// TESTING (bench instantiates this block with the datapath, defaults unless stated)
//  1 DinA=4'b0101, start pulse -> ALoad c1, BLoad c3 Muxsel=1, out_ctrl c4, done c5, DoutB=8, match=1.
//  2 DinA=4'b0011, start pulse -> Muxsel=0 during BLoad, done c5, DoutB=13, match=0.
//  3 start held high 3 runs, DinA 5,7,5 -> DoutB 8,13,8; done every 6 cycles; start in busy ignored.
//  4 SETTLE_CYCLES=3, OUT_CYCLES=2 -> BLoad c5, out_ctrl c6-c7, done c8; Astatus toggled in CHECK
//    before last cycle has no effect.
//  5 reset asserted during OUTPUT -> all outputs 0 same cycle, state IDLE; fresh run after release
//    with DinA=5 -> DoutB=8.
//  6 Assertion across all runs: ALoad+BLoad+out_ctrl <= 1 every cycle; done width exactly 1.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the A/B datapath controller: state encoding and datapath constants.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    CHECK  = 3'd2,
    LOAD_B = 3'd3,
    OUTPUT = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] A_MATCH_VAL   = 4'b0101;
  localparam logic [3:0] B_MATCH_VAL   = 4'd8;
  localparam logic [3:0] B_NOMATCH_VAL = 4'd13;

  // A wait of N cycles is realised by loading N-1 and counting down to zero.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/datapath_controller_wait_counter.sv
// Loadable 4-bit down-counter with zero flag; stops at zero rather than wrapping.
module ctrl_wait_counter
  import datapath_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/datapath_controller.sv
// Sequencing FSM for the 4-bit A/B datapath: load A, test it, load B with 8/13, publish B.
module datapath_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned OUT_CYCLES    = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic Astatus,
  output logic ALoad,
  output logic BLoad,
  output logic Muxsel,
  output logic out_ctrl,
  output logic busy,
  output logic done,
  output logic match
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   match_q, match_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  ctrl_wait_counter u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    match_d      = match_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    ALoad        = 1'b0;
    BLoad        = 1'b0;
    out_ctrl     = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_A;
      end
      LOAD_A: begin
        ALoad        = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = wait_load(SETTLE_CYCLES);
        state_d      = CHECK;
      end
      CHECK: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          // Astatus is captured only here, once per run.
          sel_d   = Astatus;
          match_d = Astatus;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        BLoad        = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = wait_load(OUT_CYCLES);
        state_d      = OUTPUT;
      end
      OUTPUT: begin
        out_ctrl = 1'b1;
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      match_q <= match_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign Muxsel = sel_q;
  assign match  = match_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench: two controllers (default and 3/2 waits), each driving a behavioural A/B datapath.
module tb_datapath_controller;
  import datapath_ctrl_pkg::*;

  typedef struct {
    int         d;
    logic [3:0] dout;
    logic       m;
  } sb_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst      [2];
  logic       start    [2];
  logic       astatus  [2];
  logic       glitch   [2];
  logic       aload    [2];
  logic       bload    [2];
  logic       muxsel   [2];
  logic       outc     [2];
  logic       busy     [2];
  logic       done     [2];
  logic       match    [2];
  logic       done_prev[2];
  logic [3:0] din      [2];
  logic [3:0] a_reg    [2];
  logic [3:0] b_reg    [2];
  logic [3:0] dout     [2];
  logic       model_sel[2];

  sb_t sbq[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc_cnt  = 0;
  int  last_done_cyc = 0;

  datapath_controller dut0 (
    .clock(clock), .reset(rst[0]), .start(start[0]), .Astatus(astatus[0]),
    .ALoad(aload[0]), .BLoad(bload[0]), .Muxsel(muxsel[0]), .out_ctrl(outc[0]),
    .busy(busy[0]), .done(done[0]), .match(match[0])
  );

  datapath_controller #(.SETTLE_CYCLES(3), .OUT_CYCLES(2)) dut1 (
    .clock(clock), .reset(rst[1]), .start(start[1]), .Astatus(astatus[1]),
    .ALoad(aload[1]), .BLoad(bload[1]), .Muxsel(muxsel[1]), .out_ctrl(outc[1]),
    .busy(busy[1]), .done(done[1]), .match(match[1])
  );

  always @(posedge clock) cyc_cnt++;

  for (genvar g = 0; g < 2; g++) begin : g_env
    initial begin
      a_reg[g]     = '0;
      b_reg[g]     = '0;
      dout[g]      = '0;
      done_prev[g] = 1'b0;
    end

    // Datapath is deliberately not reset.
    always @(posedge clock) begin
      if (aload[g]) a_reg[g] <= din[g];
      if (bload[g]) b_reg[g] <= muxsel[g] ? B_MATCH_VAL : B_NOMATCH_VAL;
      if (outc[g])  dout[g]  <= b_reg[g];
    end

    assign astatus[g] = (a_reg[g] == A_MATCH_VAL) ^ glitch[g];

    always @(negedge clock) begin
      sb_t e;
      if (!rst[g]) begin
        n_assert++;
        assert ($countones({aload[g], bload[g], outc[g]}) <= 1) else begin
          n_fail++;
          $display("FAIL onehot%0d: observed %b expected at most one set", g,
                   {aload[g], bload[g], outc[g]});
        end
        if (done[g]) begin
          n_assert++;
          assert (!done_prev[g]) else begin
            n_fail++;
            $display("FAIL done_width%0d: observed 2+ cycles expected 1", g);
          end
          if (sbq.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL sb_empty%0d: observed done expected no run outstanding", g);
          end else begin
            e = sbq.pop_front();
            n_assert++;
            assert (e.d == g && dout[g] === e.dout && match[g] === e.m) else begin
              n_fail++;
              $display("FAIL sb%0d: observed dut%0d dout=%0d match=%b expected dut%0d dout=%0d match=%b",
                       g, g, dout[g], match[g], e.d, e.dout, e.m);
            end
          end
        end
      end
      done_prev[g] = done[g];
    end
  end

  function automatic logic [5:0] sig(input int d);
    return {aload[d], bload[d], muxsel[d], outc[d], busy[d], done[d]};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a run from an IDLE cycle (called at a negedge) and checks every cycle through DONE.
  task automatic run(input int d, input logic [3:0] dv, input int s, input int o, input bit hold);
    logic       m;
    logic [5:0] expv;
    int         last;
    m    = (dv == A_MATCH_VAL);
    last = 3 + s + o;
    din[d]   = dv;
    start[d] = 1'b1;
    sbq.push_back('{d, (m ? B_MATCH_VAL : B_NOMATCH_VAL), m});
    for (int c = 1; c <= last; c++) begin
      @(posedge clock);
      #1;
      if (c == 1 && !hold) start[d] = 1'b0;
      glitch[d] = (c >= 2 && c <= s);
      @(negedge clock);
      expv = {c == 1, c == 2 + s, (c >= 2 + s) ? m : model_sel[d],
              (c >= 3 + s) && (c <= 2 + s + o), 1'b1, c == last};
      check($sformatf("run_dut%0d_din%0d_c%0d", d, dv, c), sig(d), expv);
      if (c == last) last_done_cyc = cyc_cnt;
    end
    glitch[d]    = 1'b0;
    model_sel[d] = m;
  endtask

  task automatic idle_check(input int d, input string tag);
    @(posedge clock);
    @(negedge clock);
    check(tag, sig(d), {2'b00, model_sel[d], 3'b000});
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; glitch[i] = 1'b0; din[i] = '0; model_sel[i] = 1'b0;
    end

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_dut0", sig(0), '0);
    check("reset_dut1", sig(1), '0);
    check("reset_match0", {5'b0, match[0]}, '0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clock);

    // Match and no-match runs with default waits.
    run(0, A_MATCH_VAL, 1, 1, 1'b0);
    idle_check(0, "idle_after_match");
    run(0, 4'b0011, 1, 1, 1'b0);
    idle_check(0, "idle_after_nomatch");

    // start held high for three back-to-back runs.
    run(0, 4'd5, 1, 1, 1'b1);
    t0 = last_done_cyc;
    idle_check(0, "idle_hold1");
    run(0, 4'd7, 1, 1, 1'b1);
    check_int("done_period_1", last_done_cyc - t0, 6);
    t0 = last_done_cyc;
    idle_check(0, "idle_hold2");
    run(0, 4'd5, 1, 1, 1'b0);
    check_int("done_period_2", last_done_cyc - t0, 6);
    idle_check(0, "idle_hold_end");
    idle_check(0, "idle_stays");

    // Longer waits with Astatus disturbed in early CHECK cycles.
    run(1, 4'd5, 3, 2, 1'b0);
    idle_check(1, "idle_dut1_a");
    run(1, 4'd7, 3, 2, 1'b0);
    idle_check(1, "idle_dut1_b");

    // Asynchronous reset while in OUTPUT, then a fresh run.
    din[0]   = 4'd3;
    start[0] = 1'b1;
    @(posedge clock);
    #1 start[0] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("pre_reset_output", sig(0), 6'b000110);
    #2 rst[0] = 1'b1;
    #1;
    check("async_reset_outputs", sig(0), '0);
    check("async_reset_match", {5'b0, match[0]}, '0);
    model_sel[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rst[0] = 1'b0;
    @(negedge clock);
    run(0, 4'd5, 1, 1, 1'b0);
    idle_check(0, "idle_after_reset_run");
    check("dout_after_reset_run", {2'b00, dout[0]}, {2'b00, B_MATCH_VAL});

    check_int("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
